// File: rtl/icache_ctrl.sv
// Two-way set-associative instruction cache controller (256 sets, 16-byte lines)
// with one outstanding fetch, external tag/valid/data arrays and a line refill buffer.
module icache_ctrl (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    input  logic [31:0]   req_addr,
    output logic          req_ready,
    output logic          resp_valid,
    output logic [31:0]   resp_data,
    output logic [7:0]    tv_rindex,
    input  logic [19:0]   tv_rtag0,
    input  logic [19:0]   tv_rtag1,
    input  logic [1:0]    tv_rvalid,
    output logic [7:0]    tv_windex,
    output logic [19:0]   tv_wtag,
    output logic [1:0]    tv_we,
    input  logic [127:0]  data_rline0,
    input  logic [127:0]  data_rline1,
    output logic [127:0]  data_wline,
    output logic          mem_rd_req,
    output logic [31:0]   mem_rd_addr,
    input  logic          mem_rd_rdy,
    input  logic          mem_ret_valid,
    input  logic          mem_ret_last,
    input  logic [31:0]   mem_ret_data
);
    localparam int unsigned TAG_W  = 20;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned LINE_W = WORD_W * WORDS;
    localparam int unsigned SETS   = 256;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_t;

    state_t              state_q, state_d;
    logic [29:0]         addr_q;
    logic                victim_q;
    logic [1:0]          cnt_q;
    logic [WORD_W-1:0]   buf_q [WORDS];
    logic [SETS-1:0]     lru_q;

    logic [TAG_W-1:0]    tag_q;
    logic [IDX_W-1:0]    idx_q;
    logic [1:0]          word_q;
    logic                hit0, hit1;
    logic [LINE_W-1:0]   hit_line;
    logic [WORD_W-1:0]   hit_word;
    logic [LINE_W-1:0]   merged_line;

    logic                latch_addr, latch_victim, victim_d, clr_cnt, beat_we, lru_we, lru_d;
    logic                unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    assign tag_q  = addr_q[29:10];
    assign idx_q  = addr_q[9:2];
    assign word_q = addr_q[1:0];

    // Array read index follows the incoming request while idle so lookup data is ready next cycle
    assign tv_rindex   = (state_q == IDLE) ? req_addr[11:4] : idx_q;
    assign tv_windex   = idx_q;
    assign tv_wtag     = tag_q;
    assign mem_rd_addr = {addr_q[29:2], 4'h0};
    assign data_wline  = merged_line;

    assign hit0     = tv_rvalid[0] && (tv_rtag0 == tag_q);
    assign hit1     = tv_rvalid[1] && (tv_rtag1 == tag_q);
    assign hit_line = hit0 ? data_rline0 : data_rline1;
    assign hit_word = hit_line[{word_q, 5'b0} +: WORD_W];

    // Refill buffer with the current beat merged in, so the last beat writes the full line
    always_comb begin
        merged_line = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            merged_line[k*WORD_W +: WORD_W] =
                (beat_we && cnt_q == 2'(k)) ? mem_ret_data : buf_q[k];
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_data    = '0;
        mem_rd_req   = 1'b0;
        tv_we        = 2'b00;
        latch_addr   = 1'b0;
        latch_victim = 1'b0;
        victim_d     = 1'b0;
        clr_cnt      = 1'b0;
        beat_we      = 1'b0;
        lru_we       = 1'b0;
        lru_d        = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    latch_addr = 1'b1;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit0 || hit1) begin
                    resp_valid = 1'b1;
                    resp_data  = hit_word;
                    lru_we     = 1'b1;
                    lru_d      = hit0;
                    state_d    = IDLE;
                end else begin
                    latch_victim = 1'b1;
                    victim_d     = !tv_rvalid[0] ? 1'b0 :
                                   !tv_rvalid[1] ? 1'b1 : lru_q[idx_q];
                    state_d      = MISS;
                end
            end
            MISS: begin
                mem_rd_req = 1'b1;
                if (mem_rd_rdy) begin
                    clr_cnt = 1'b1;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_ret_valid) begin
                    beat_we = 1'b1;
                    if (mem_ret_last) begin
                        tv_we   = victim_q ? 2'b10 : 2'b01;
                        lru_we  = 1'b1;
                        lru_d   = ~victim_q;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = buf_q[word_q];
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset abandons any transaction in flight: no handshakes, writes or beats
        if (!rstn) begin
            req_ready  = 1'b0;
            resp_valid = 1'b0;
            mem_rd_req = 1'b0;
            tv_we      = 2'b00;
            beat_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            victim_q <= 1'b0;
            cnt_q    <= '0;
            lru_q    <= '0;
        end else begin
            state_q <= state_d;
            if (latch_addr)   addr_q   <= req_addr[31:2];
            if (latch_victim) victim_q <= victim_d;
            if (clr_cnt)      cnt_q    <= '0;
            else if (beat_we) cnt_q    <= cnt_q + 2'd1;
            if (lru_we)       lru_q[idx_q] <= lru_d;
        end
    end

    // Refill buffer keeps stale words across transactions and reset
    always_ff @(posedge clk) begin
        if (beat_we) buf_q[cnt_q] <= mem_ret_data;
    end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameters: none; geometry fixed: 2 ways, 256 sets, 16-byte lines (4 x 32-bit words); address split tag[31:12], index[11:4], word[3:2].
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  CPU fetch request.
REQ-005 req_addr  in  32  fetch byte address; bits[1:0] ignored.
REQ-006 req_ready  out  1  request accepted on a cycle with req_valid && req_ready.
REQ-007 resp_valid  out  1  one-cycle pulse; resp_data valid; no backpressure.
REQ-008 resp_data  out  32  fetched word.
REQ-009 tv_rindex  out  8  read index to both tag/valid ways (combinational read).
REQ-010 tv_rtag0, tv_rtag1  in  20 each  stored tags of way 0/1 at tv_rindex.
REQ-011 tv_rvalid  in  2  valid bits of way 1/0 at tv_rindex.
REQ-012 tv_windex  out  8  write index, shared by tag/valid and data arrays.
REQ-013 tv_wtag  out  20  tag written (array sets valid itself).
REQ-014 tv_we  out  2  one-hot per-way write enable, tag/valid and data arrays.
REQ-015 data_rline0, data_rline1  in  128 each  line data of way 0/1 at tv_rindex (combinational).
REQ-016 data_wline  out  128  refill line; word k at bits [32k+31:32k].
REQ-017 mem_rd_req  out  1  line read request to memory.
REQ-018 mem_rd_addr  out  32  line-aligned address ({tag,index,4'b0}).
REQ-019 mem_rd_rdy  in  1  memory accepts request when mem_rd_req && mem_rd_rdy.
REQ-020 mem_ret_valid, mem_ret_last  in  1 each  return beat valid / final beat.
REQ-021 mem_ret_data  in  32  return beat data, ascending word order from word 0.

Function
REQ-022 States: IDLE, LOOKUP, MISS, REFILL, RESP; one request outstanding at a time.
REQ-023 IDLE: req_ready=1; on handshake latch req_addr, go LOOKUP; otherwise stay.
REQ-024 req_ready SHALL be 0 in every state except IDLE.
REQ-025 tv_rindex SHALL equal the latched index in LOOKUP/MISS/REFILL/RESP and req_addr[11:4] in IDLE.
REQ-026 LOOKUP: hit_w = tv_rvalid[w] && tv_rtag_w == latched tag; both-hit resolves to way 0.
REQ-027 LOOKUP hit: resp_valid=1 same cycle, resp_data = selected word of hitting way line; lru[index] set to the other way; go IDLE (hit latency 2 cycles from accept).
REQ-028 LOOKUP miss: choose victim = way 0 if invalid, else way 1 if invalid, else lru[index]; latch victim; go MISS.
REQ-029 MISS: mem_rd_req=1 with mem_rd_addr held stable until mem_rd_rdy; on handshake go REFILL, clear 2-bit beat counter.
REQ-030 REFILL: each mem_ret_valid beat stores mem_ret_data into buffer word[counter], counter increments (wraps 3->0); beats without mem_ret_valid ignored.
REQ-031 REFILL beat with mem_ret_last: same cycle tv_we[victim]=1, tv_windex=index, tv_wtag=tag, data_wline = buffer with that beat merged; lru[index] set to other way; go RESP.
REQ-032 Early mem_ret_last (<4 beats): refill completes anyway; unreceived words take stale buffer contents; no error flag.
REQ-033 RESP: resp_valid=1, resp_data = requested word from refill buffer (not the array); go IDLE.
REQ-034 tv_we SHALL be 0 outside the last refill beat; mem_rd_req 0 outside MISS; resp_valid 0 outside LOOKUP-hit and RESP.
REQ-035 lru: 256 x 1-bit internal array; value = way to evict next when both valid.

Reset
REQ-036 rstn low at any edge, including mid-MISS/REFILL: state IDLE, lru all 0, beat counter 0, latched address 0; refill abandoned, no tag write.
REQ-037 During and the cycle after reset: req_ready=0 while rstn low, then 1; resp_valid, mem_rd_req, tv_we all 0.
REQ-038 Memory beats arriving after a mid-refill reset SHALL be ignored in IDLE.

Verification
REQ-039 Cold miss: req 0x0000_1024, arrays empty -> mem_rd_addr 0x0000_1020; beats 0xA0..0xA3 -> tv_we=2'b01, tv_windex=0x02, tv_wtag=0x00001; resp_data 0xA1.
REQ-040 Hit: repeat 0x0000_1024 with way-0 model updated -> resp_valid 2 cycles after accept, no mem_rd_req, resp_data 0xA1.
REQ-041 Replacement: fill index 0x02 with tags 0x00001 (way0), 0x00002 (way1), hit tag 0x00001, miss tag 0x00003 -> victim way 1 (tv_we=2'b10).
REQ-042 Stall: mem_rd_rdy low 5 cycles -> mem_rd_req held, mem_rd_addr constant, req_ready 0.
REQ-043 Reset mid-refill after 2 beats -> IDLE next cycle, tv_we never asserted, following miss to same address refills normally.
